// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode helpers shared by the serial ALU
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction

endpackage

// File: rtl/alu_slice_c.sv
// alu_slice_c: combinational 1-bit ALU slice; sub adds the inverted b, unknown opcodes give 0
module alu_slice_c
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       y,
    output logic       cout
);

    logic bb;
    logic arith;

    // bit result and carry; logic and invalid ops never propagate a carry
    always_comb begin
        bb    = (op == OP_SUB) ? ~b : b;
        arith = is_arith(op);
        y     = arith ? a ^ bb ^ cin :
                (op == OP_AND) ? a & b :
                (op == OP_OR)  ? a | b :
                (op == OP_XOR) ? a ^ b : 1'b0;
        cout  = arith ? (a & bb) | (a & cin) | (bb & cin) : 1'b0;
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU controller, LSB first; SERIAL_ALU_OVF_EN adds the overflow output
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef SERIAL_ALU_OVF_EN
    output logic             overflow,
`endif
    output logic             zero_flag
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [2:0]       op;
    logic             c_reg;
    logic             y;
    logic             cout;

    alu_slice_c u_slice (
        .op   (op),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_reg),
        .y    (y),
        .cout (cout)
    );

    // FSM: capture in IDLE, one bit per RUN cycle, hold outputs in DONE until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            op        <= OP_ADD;
            c_reg     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero_flag <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SERIAL_ALU_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr     <= A;
                    b_sr     <= B;
                    op       <= select;
                    c_reg    <= (select == OP_SUB);
                    idx      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    a_sr        <= a_sr >> 1;
                    b_sr        <= b_sr >> 1;
                    c_reg       <= cout;
                    result[idx] <= y;
                    idx         <= idx + IW'(1);
                    if (idx == LAST) begin
                        idx       <= '0;
                        carry_out <= cout;
                        zero_flag <= ~|{y, result[WIDTH-2:0]};
`ifdef SERIAL_ALU_OVF_EN
                        overflow  <= c_reg ^ cout;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid  input  1  operation request valid.
REQ-005 SHALL provide port in_ready  output  1  controller can accept a request.
REQ-006 SHALL provide port A  input  WIDTH  operand A.
REQ-007 SHALL provide port B  input  WIDTH  operand B.
REQ-008 SHALL provide port select  input  3  opcode: add 000, sub 001, and 010, or 100, xor 110.
REQ-009 SHALL provide port out_valid  output  1  result valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port result  output  WIDTH  operation result.
REQ-012 SHALL provide port carry_out  output  1  final carry (add/sub), 0 otherwise.
REQ-013 SHALL provide port zero_flag  output  1  1 when result == 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE is the reset state.
REQ-015 SHALL drive in_ready=1 only in IDLE; in_valid&&in_ready captures A, B and select, then moves to RUN.
REQ-016 SHALL process one bit per RUN cycle, LSB first, using a bit index counter that runs 0..WIDTH-1; RUN lasts exactly WIDTH cycles.
REQ-017 SHALL seed the inter-bit carry register with 0 for add and 1 for sub; sub computes A + ~B + 1.
REQ-018 SHALL shift each slice result bit into the result register at position index.
REQ-019 SHALL enter DONE after index WIDTH-1; out_valid=1 only in DONE; first out_valid is WIDTH+1 cycles after the accept edge.
REQ-020 SHALL hold result, carry_out and zero_flag stable while out_valid=1 && out_ready=0.
REQ-021 SHALL return to IDLE on out_valid&&out_ready; in_ready rises the next cycle. No accept is allowed in DONE.
REQ-022 SHALL set carry_out to the carry out of bit WIDTH-1 for add/sub (sub: 1 = no borrow, A>=B unsigned), else 0.
REQ-023 SHALL treat select 011, 101 and 111 as invalid: full RUN duration, result 0, carry_out 0, zero_flag 1.
REQ-024 SHALL ignore changes on A, B and select outside the accept cycle.

Reset
REQ-025 SHALL force state IDLE, index 0, carry register 0, result 0, carry_out 0, zero_flag 0, out_valid 0 and in_ready 1 while rst_n=0, including mid-RUN or mid-DONE; any in-flight operation is discarded.
REQ-026 SHALL NOT accept a request on the first rising edge at which rst_n is sampled low.

Configuration
REQ-027 With macro SERIAL_ALU_OVF_EN defined, SHALL add output port overflow (1 bit): signed overflow of the add/sub (carry into MSB XOR carry out of MSB), 0 for logic ops; it is valid and held with out_valid and reset to 0.
REQ-028 Without SERIAL_ALU_OVF_EN, the overflow port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 SHALL place the opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR) and the FSM state encoding in shared package alu_pkg.
REQ-030 SHALL implement the per-bit datapath as sub-module alu_slice_c: a combinational 1-bit slice with a real carry input, outputs sum/logic bit and carry.
REQ-031 The top level SHALL contain only the FSM, counter, operand shift registers, carry register and result register.

Verification (WIDTH=8)
REQ-032 add A=0xFF B=0x01 -> out_valid 9 cycles after accept; result 0x00, carry_out 1, zero_flag 1.
REQ-033 sub A=0x05 B=0x07 -> result 0xFE, carry_out 0, zero_flag 0; with OVF_EN, add 0x7F+0x01 -> result 0x80, overflow 1.
REQ-034 xor A=0xA5 B=0xA5 -> result 0x00, zero_flag 1, carry_out 0; or 0xA0|0x05 -> 0xA5.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable and in_ready 0 throughout; IDLE and in_ready 1 the cycle after out_ready=1.
REQ-036 rst_n pulsed low at RUN index 3 -> all outputs at reset values, in_ready 1, and a new add 0x01+0x01 afterwards yields 0x02.
REQ-037 select 011 with A=0xFF B=0xFF -> result 0x00, carry_out 0, zero_flag 1, latency 9 cycles.
